// File: rtl/imm_extend_pipe.sv
// Immediate expander for ARM decode: rotate, 12-bit, branch, halfword, SVC modes plus illegal flag/counter.
// Latency: 2 cycles (S1 input register, S2 result register), 1 result per cycle.
// Backpressure: S2 holds while out_ready=0; in_ready drops only when both stages are full and stalled.
module imm_extend_pipe #(
  parameter int XLEN      = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [23:0]          instr,
  input  logic [2:0]           imm_src,
  input  logic                 carry_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      ext_imm,
  output logic                 carry_out,
  output logic                 imm_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    MODE_ROT  = 3'b000,
    MODE_U12  = 3'b001,
    MODE_BR   = 3'b010,
    MODE_HALF = 3'b011,
    MODE_SVC  = 3'b100
  } mode_e;

  logic        s1_valid;
  logic [23:0] s1_instr;
  logic [2:0]  s1_mode;
  logic        s1_carry;
  logic [4:0]  s1_rot;
  logic        s1_illegal;
  logic        s2_valid;

  logic        s2_load;
  logic        s1_advance;
  logic        accept;
  logic        in_illegal;

  logic [31:0]     imm8_32;
  logic [31:0]     rot_val;
  logic [XLEN-1:0] nxt_imm;
  logic            nxt_carry;
  logic            nxt_err;

  assign s2_load    = !s2_valid || out_ready;
  assign s1_advance = s1_valid && s2_load;
  assign in_ready   = !s1_valid || s1_advance;
  assign accept     = in_valid && in_ready;
  assign in_illegal = (imm_src > 3'd4);
  assign out_valid  = s2_valid;

  // A left shift by 32 yields zero, so rot == 0 needs no special case here.
  assign imm8_32 = {24'd0, s1_instr[7:0]};
  assign rot_val = (imm8_32 >> s1_rot) | (imm8_32 << (6'd32 - {1'b0, s1_rot}));

  always_comb begin
    nxt_imm   = '0;
    nxt_carry = s1_carry;
    nxt_err   = 1'b0;
    if (s1_illegal) begin
      nxt_carry = 1'b0;
      nxt_err   = 1'b1;
    end else begin
      case (s1_mode)
        MODE_ROT: begin
          nxt_imm[31:0] = rot_val;
          nxt_carry     = (s1_rot == 5'd0) ? s1_carry : rot_val[31];
        end
        MODE_U12:  nxt_imm[11:0] = s1_instr[11:0];
        MODE_BR: begin
          nxt_imm       = {XLEN{s1_instr[23]}};
          nxt_imm[25:0] = {s1_instr, 2'b00};
        end
        MODE_HALF: nxt_imm[7:0]  = {s1_instr[11:8], s1_instr[3:0]};
        MODE_SVC:  nxt_imm[23:0] = s1_instr;
        default:   nxt_imm = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid   <= 1'b0;
      s1_instr   <= '0;
      s1_mode    <= '0;
      s1_carry   <= 1'b0;
      s1_rot     <= '0;
      s1_illegal <= 1'b0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_instr   <= instr;
      s1_mode    <= imm_src;
      s1_carry   <= carry_in;
      s1_rot     <= {instr[11:8], 1'b0};
      s1_illegal <= in_illegal;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Result registers only change on a load that carries data, keeping a stalled output stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid  <= 1'b0;
      ext_imm   <= '0;
      carry_out <= 1'b0;
      imm_err   <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        ext_imm   <= nxt_imm;
        carry_out <= nxt_carry;
        imm_err   <= nxt_err;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt <= '0;
    end else if (accept && in_illegal && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule
